// File: rtl/buffer_pkg.sv
// Shared helpers for the stream buffers: pointer arithmetic for
// non-power-of-two depths, occupancy counter sizing and the IF tag width.
package buffer_pkg;

    // The IF path widens each word by this many tag bits.
    localparam int IF_TAG_W = 2;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a storage index; a single-entry buffer still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Modular pointer advance. The increment never exceeds depth, so one
    // conditional subtraction is enough and depth need not be a power of two.
    function automatic int ptr_advance(input int ptr, input int inc, input int depth);
        int sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/stream_width_fifo_if.sv
// Handshake bundle between a stream producer/consumer and stream_width_fifo.
// The parameters here must match those given to the FIFO it connects to.
interface stream_width_fifo_if
    import buffer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1
);

    localparam int CNT_W = count_width(DEPTH);

    logic                       flush;
    logic                       wen;
    logic [PAR_WRITE*WIDTH-1:0] din;
    logic                       ren;
    logic [PAR_READ*WIDTH-1:0]  dout;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [CNT_W-1:0]           count;
    logic                       overflow;
    logic                       underflow;

    // The side that pushes and pops words.
    modport master (
        output flush, wen, din, ren,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  flush, wen, din, ren,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag bookkeeping for stream_width_fifo. Storage
// lives in the parent; this block only decides what is accepted.
module fifo_ptr_ctrl
    import buffer_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wen,
    input  logic                          ren,
    output logic [ptr_width(DEPTH)-1:0]   wr_ptr,
    output logic [ptr_width(DEPTH)-1:0]   rd_ptr,
    output logic                          w_acc,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic             r_acc;
    logic [CNT_W-1:0] count_next;

    // Flags come straight from the registered count, so a same-cycle read
    // never makes room for a same-cycle write.
    assign full         = (DEPTH - int'(count)) < PAR_WRITE;
    assign empty        = int'(count) < PAR_READ;
    assign almost_full  = int'(count) >= AFULL_TH;
    assign almost_empty = int'(count) <= AEMPTY_TH;

    // A flush swallows both requests in the same cycle.
    assign w_acc = wen && !full && !flush;
    assign r_acc = ren && !empty && !flush;

    // Net occupancy change when both sides may move in one cycle.
    always_comb begin
        count_next = count;
        count_next = CNT_W'(int'(count) + (w_acc ? PAR_WRITE : 0) - (r_acc ? PAR_READ : 0));
    end

    // Pointer/count registers with sticky error capture; flush outranks
    // everything except the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_acc) begin
                wr_ptr <= PTR_W'(ptr_advance(int'(wr_ptr), PAR_WRITE, DEPTH));
            end
            if (r_acc) begin
                rd_ptr <= PTR_W'(ptr_advance(int'(rd_ptr), PAR_READ, DEPTH));
            end
            count <= count_next;
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_width_fifo.sv
// Multi-lane show-ahead stream FIFO: PAR_WRITE words in and PAR_READ words
// out per handshake, any depth. Lane 0 is always the oldest word.
module stream_width_fifo
    import buffer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic               clk,
    input  logic               rst,
    stream_width_fifo_if.slave bus
);

    localparam int PTR_W = ptr_width(DEPTH);

    // Parameter sanity checks, caught at elaboration.
    if (DEPTH < PAR_WRITE) begin : g_chk_write
        $error("stream_width_fifo: DEPTH smaller than PAR_WRITE");
    end
    if (DEPTH < PAR_READ) begin : g_chk_read
        $error("stream_width_fifo: DEPTH smaller than PAR_READ");
    end
    if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_chk_th
        $error("stream_width_fifo: thresholds out of order");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             w_acc;
    logic             has_data;

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .PAR_WRITE (PAR_WRITE),
        .PAR_READ  (PAR_READ),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.flush),
        .wen          (bus.wen),
        .ren          (bus.ren),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .w_acc        (w_acc),
        .count        (bus.count),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

    // Lane-wise store; each lane lands at its own wrapped address so a
    // burst can straddle the end of the array.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < PAR_WRITE; k++) begin
                mem[PTR_W'(ptr_advance(int'(wr_ptr), k, DEPTH))] <= bus.din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Storage is never cleared, so remember whether anything was ever
    // written and keep dout at zero until then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_data <= 1'b0;
        end else if (w_acc) begin
            has_data <= 1'b1;
        end
    end

    // Show-ahead read mux: head words appear as soon as they are stored.
    always_comb begin
        bus.dout = '0;
        if (has_data) begin
            for (int k = 0; k < PAR_READ; k++) begin
                bus.dout[k*WIDTH +: WIDTH] = mem[PTR_W'(ptr_advance(int'(rd_ptr), k, DEPTH))];
            end
        end
    end

endmodule
